// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIF unit: instruction codes, EX->WB and WB->regfile
// payloads, and the writeback FSM state encoding.
package fir_xifu_pkg;

  localparam int X_ID_WIDTH = 4;

  typedef enum logic [1:0] {
    INSTR_INVALID = 2'd0,
    XFIRLW        = 2'd1,
    XFIRSW        = 2'd2,
    XFIRDOTP      = 2'd3
  } fir_xifu_instr_t;

  typedef struct packed {
    fir_xifu_instr_t         instr;
    logic [X_ID_WIDTH-1:0]   id;
    logic [4:0]              rd;
    logic [31:0]             result;
  } fir_xifu_ex2wb_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        write;
  } fir_xifu_wb2regfile_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_COMMIT = 2'd1,
    RESULT      = 2'd2
  } fir_xifu_wb_state_t;

  // Only loads and dot products produce a value for the internal register file.
  function automatic logic writes_regfile(input fir_xifu_instr_t instr);
    return (instr == XFIRLW) || (instr == XFIRDOTP);
  endfunction

endpackage

// File: rtl/fir_xifu_commit_table.sv
// Per-ID commit/kill tracker: one {done, killed} pair per XIF instruction ID.
// Lookup reflects registered state only, so a set becomes visible next cycle.
module fir_xifu_commit_table #(
  parameter int ID_WIDTH = fir_xifu_pkg::X_ID_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                set_valid_i,
  input  logic [ID_WIDTH-1:0] set_id_i,
  input  logic                set_kill_i,
  input  logic                clr_valid_i,
  input  logic [ID_WIDTH-1:0] clr_id_i,
  input  logic [ID_WIDTH-1:0] lookup_id_i,
  output logic                lookup_done_o,
  output logic                lookup_killed_o
);

  localparam int DEPTH = 1 << ID_WIDTH;

  logic [DEPTH-1:0] done_q;
  logic [DEPTH-1:0] killed_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_q   <= '0;
      killed_q <= '0;
    end else begin
      if (clr_valid_i) begin
        done_q[clr_id_i]   <= 1'b0;
        killed_q[clr_id_i] <= 1'b0;
      end
      // Placed after the clear so a set to the same ID overrides it.
      if (set_valid_i) begin
        done_q[set_id_i]   <= 1'b1;
        killed_q[set_id_i] <= set_kill_i;
      end
    end
  end

  assign lookup_done_o   = done_q[lookup_id_i];
  assign lookup_killed_o = killed_q[lookup_id_i];

endmodule

// File: rtl/fir_xifu_wb.sv
// Writeback stage of the FIR XIF unit: holds one EX result, waits for its
// commit, writes the internal regfile and returns the XIF result.
// Define FIR_XIFU_WB_COMMIT_EN to track commits; otherwise every entry is
// treated as committed after a single WAIT_COMMIT cycle.
module fir_xifu_wb #(
  parameter int X_ID_WIDTH = fir_xifu_pkg::X_ID_WIDTH
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  fir_xifu_pkg::fir_xifu_ex2wb_t      ex2wb_i,
  input  logic                               ex2wb_valid_i,
  output logic                               ex2wb_ready_o,
  input  logic                               commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]              commit_id_i,
  input  logic                               commit_kill_i,
  output fir_xifu_pkg::fir_xifu_wb2regfile_t wb2regfile_o,
  output logic                               result_valid_o,
  input  logic                               result_ready_i,
  output logic [X_ID_WIDTH-1:0]              result_id_o,
  output logic [31:0]                        result_data_o,
  output logic [4:0]                         result_rd_o,
  output logic                               result_we_o,
  output fir_xifu_pkg::fir_xifu_wb_state_t   dbg_state_o
);

  import fir_xifu_pkg::*;

  // Handshakes: a transfer happens in any cycle where valid and ready are both
  // high; valid never depends on ready, and the producer holds its payload
  // until the transfer cycle.

  fir_xifu_wb_state_t state_q;
  fir_xifu_ex2wb_t    entry_q;
  logic               accept;
  logic               resolved;
  logic               killed;
  logic               resolve_now;

  assign ex2wb_ready_o = (state_q == IDLE) || ((state_q == RESULT) && result_ready_i);
  assign accept        = ex2wb_valid_i && ex2wb_ready_o;
  assign resolve_now   = (state_q == WAIT_COMMIT) && resolved;

`ifdef FIR_XIFU_WB_COMMIT_EN
  logic lookup_done;
  logic lookup_killed;

  fir_xifu_commit_table #(
    .ID_WIDTH (X_ID_WIDTH)
  ) u_commit_table (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .set_valid_i     (commit_valid_i),
    .set_id_i        (commit_id_i),
    .set_kill_i      (commit_kill_i),
    .clr_valid_i     (resolve_now),
    .clr_id_i        (entry_q.id),
    .lookup_id_i     (entry_q.id),
    .lookup_done_o   (lookup_done),
    .lookup_killed_o (lookup_killed)
  );

  assign resolved = lookup_done;
  assign killed   = lookup_killed;
`else
  logic unused_commit;
  assign unused_commit = ^{commit_valid_i, commit_id_i, commit_kill_i};
  assign resolved      = 1'b1;
  assign killed        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      entry_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            entry_q <= ex2wb_i;
            state_q <= WAIT_COMMIT;
          end
        end
        WAIT_COMMIT: begin
          if (resolved) state_q <= killed ? IDLE : RESULT;
        end
        RESULT: begin
          if (result_ready_i) begin
            if (accept) begin
              entry_q <= ex2wb_i;
              state_q <= WAIT_COMMIT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The write pulse is gated by reset so an entry resolving in a reset cycle is dropped.
  always_comb begin
    wb2regfile_o = '0;
    if (resolve_now && !killed && !rst_i && writes_regfile(entry_q.instr)) begin
      wb2regfile_o.write  = 1'b1;
      wb2regfile_o.rd     = entry_q.rd;
      wb2regfile_o.result = entry_q.result;
    end
  end

  assign result_valid_o = (state_q == RESULT);
  assign result_id_o    = result_valid_o ? entry_q.id     : '0;
  assign result_data_o  = result_valid_o ? entry_q.result : '0;
  assign result_rd_o    = result_valid_o ? entry_q.rd     : '0;
  assign result_we_o    = 1'b0;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_fir_xifu_wb.sv
// Directed bench for fir_xifu_wb; commit-tracking cases run when
// FIR_XIFU_WB_COMMIT_EN is defined, the fixed-latency case otherwise.
module tb_fir_xifu_wb;
  import fir_xifu_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  fir_xifu_ex2wb_t      ex2wb = '0;
  logic                 ex2wb_valid = 1'b0;
  logic                 ex2wb_ready;
  logic                 commit_valid = 1'b0;
  logic [3:0]           commit_id = '0;
  logic                 commit_kill = 1'b0;
  fir_xifu_wb2regfile_t wb;
  logic                 result_valid;
  logic                 result_ready = 1'b0;
  logic [3:0]           result_id;
  logic [31:0]          result_data;
  logic [4:0]           result_rd;
  logic                 result_we;
  fir_xifu_wb_state_t   dbg_state;

  int total = 0;
  int bad   = 0;

  fir_xifu_wb dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ex2wb_i        (ex2wb),
    .ex2wb_valid_i  (ex2wb_valid),
    .ex2wb_ready_o  (ex2wb_ready),
    .commit_valid_i (commit_valid),
    .commit_id_i    (commit_id),
    .commit_kill_i  (commit_kill),
    .wb2regfile_o   (wb),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready),
    .result_id_o    (result_id),
    .result_data_o  (result_data),
    .result_rd_o    (result_rd),
    .result_we_o    (result_we),
    .dbg_state_o    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input fir_xifu_instr_t instr, input logic [3:0] id,
                       input logic [4:0] rd, input logic [31:0] data);
    ex2wb_valid  = v;
    ex2wb.instr  = instr;
    ex2wb.id     = id;
    ex2wb.rd     = rd;
    ex2wb.result = data;
  endtask

  task automatic idle_in();
    drive(1'b0, INSTR_INVALID, 4'd0, 5'd0, 32'd0);
  endtask

  task automatic commit(input logic v, input logic [3:0] id, input logic kill);
    commit_valid = v;
    commit_id    = id;
    commit_kill  = kill;
  endtask

  function automatic fir_xifu_wb2regfile_t wr(input logic [31:0] data, input logic [4:0] rd);
    fir_xifu_wb2regfile_t w;
    w.result = data;
    w.rd     = rd;
    w.write  = 1'b1;
    return w;
  endfunction

  fir_xifu_instr_t t_instr[3] = '{XFIRLW, INSTR_INVALID, XFIRDOTP};
  logic [3:0]      t_id[3]    = '{4'd1, 4'd8, 4'd15};
  logic [4:0]      t_rd[3]    = '{5'd31, 5'd3, 5'd0};
  logic [31:0]     t_data[3]  = '{32'hFFFF_FFFF, 32'h0000_0055, 32'hA5A5_A5A5};

  initial begin
    fir_xifu_wb2regfile_t exp_wb;

    repeat (3) cyc();
    rst = 1'b0;
    #1;
    check("rst_state", dbg_state, IDLE);
    check("rst_ready", ex2wb_ready, 1'b1);
    check("rst_rvalid", result_valid, 1'b0);
    check("rst_wb", wb, '0);
    check("rst_rid", result_id, 4'd0);
    check("rst_rdata", result_data, 32'd0);
    check("rst_rrd", result_rd, 5'd0);
    check("rst_we", result_we, 1'b0);
    cyc();

    // Commit id 3 two cycles before the DOTP arrives
    commit(1'b1, 4'd3, 1'b0);
    cyc();
    commit(1'b0, 4'd0, 1'b0);
    cyc();
    drive(1'b1, XFIRDOTP, 4'd3, 5'd5, 32'h1234_5678);
    #1 check("cbd_ready", ex2wb_ready, 1'b1);
    cyc();
    idle_in();
    #1;
    check("cbd_wb", wb, wr(32'h1234_5678, 5'd5));
    check("cbd_state_n1", dbg_state, WAIT_COMMIT);
    check("cbd_rvalid_n1", result_valid, 1'b0);
    cyc();
    check("cbd_rvalid_n2", result_valid, 1'b1);
    check("cbd_rid", result_id, 4'd3);
    check("cbd_rdata", result_data, 32'h1234_5678);
    check("cbd_rrd", result_rd, 5'd5);
    check("cbd_we", result_we, 1'b0);
    check("cbd_wb_off", wb.write, 1'b0);

    // Backpressure with XFIRSW id 2 waiting at the input
    drive(1'b1, XFIRSW, 4'd2, 5'd9, 32'hCAFE_0002);
    commit(1'b1, 4'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready", ex2wb_ready, 1'b0);
      check("bp_rvalid", result_valid, 1'b1);
      check("bp_rid", result_id, 4'd3);
      check("bp_rdata", result_data, 32'h1234_5678);
      cyc();
      commit(1'b0, 4'd0, 1'b0);
    end
    result_ready = 1'b1;
    #1 check("bp_release_ready", ex2wb_ready, 1'b1);
    cyc();
    idle_in();
    #1;
    check("sw_wb", wb, '0);
    check("sw_state", dbg_state, WAIT_COMMIT);
    cyc();
    check("sw_rvalid", result_valid, 1'b1);
    check("sw_rid", result_id, 4'd2);
    check("sw_rdata", result_data, 32'hCAFE_0002);
    check("sw_rrd", result_rd, 5'd9);
    cyc();
    check("sw_idle", dbg_state, IDLE);
    check("sw_rvalid_off", result_valid, 1'b0);

    // Back-to-back stream: one instruction every two cycles
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, t_instr[i], t_id[i], t_rd[i], t_data[i]);
      commit(1'b1, t_id[i], 1'b0);
      #1;
      check("tp_ready", ex2wb_ready, 1'b1);
      if (i > 0) check("tp_prev_rid", result_id, t_id[i-1]);
      cyc();
      idle_in();
      commit(1'b0, 4'd0, 1'b0);
      exp_wb = '0;
      if (t_instr[i] == XFIRLW || t_instr[i] == XFIRDOTP) exp_wb = wr(t_data[i], t_rd[i]);
      #1 check("tp_wb", wb, exp_wb);
      cyc();
    end
    check("tp_last_rvalid", result_valid, 1'b1);
    check("tp_last_rdata", result_data, 32'hA5A5_A5A5);
    cyc();
    check("tp_idle", dbg_state, IDLE);

    // Reset landing in the resolving WAIT_COMMIT cycle
    drive(1'b1, XFIRDOTP, 4'd10, 5'd10, 32'h0BAD_0BAD);
    commit(1'b1, 4'd10, 1'b0);
    cyc();
    idle_in();
    commit(1'b0, 4'd0, 1'b0);
    rst = 1'b1;
    #1 check("rstmid_wb", wb.write, 1'b0);
    cyc();
    rst = 1'b0;
    #1 check("rstmid_state", dbg_state, IDLE);
    cyc();
    check("rstmid_rvalid", result_valid, 1'b0);
    check("rstmid_wb2", wb.write, 1'b0);

`ifdef FIR_XIFU_WB_COMMIT_EN
    // Kill of XFIRLW id 7
    drive(1'b1, XFIRLW, 4'd7, 5'd7, 32'h7777_7777);
    cyc();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      #1 check("kill_wait_wb", wb.write, 1'b0);
      check("kill_wait_state", dbg_state, WAIT_COMMIT);
      cyc();
    end
    commit(1'b1, 4'd7, 1'b1);
    #1 check("kill_nobypass", dbg_state, WAIT_COMMIT);
    cyc();
    commit(1'b0, 4'd0, 1'b0);
    #1 check("kill_wb", wb.write, 1'b0);
    cyc();
    check("kill_idle", dbg_state, IDLE);
    check("kill_rvalid", result_valid, 1'b0);
    // Entry 7 must have been cleared: a new id 7 waits
    drive(1'b1, XFIRLW, 4'd7, 5'd8, 32'h8888_8888);
    cyc();
    idle_in();
    cyc();
    check("kill_cleared_state", dbg_state, WAIT_COMMIT);
    commit(1'b1, 4'd7, 1'b0);
    #1 check("commit_nobypass_wb", wb.write, 1'b0);
    cyc();
    commit(1'b0, 4'd0, 1'b0);
    #1 check("commit7_wb", wb, wr(32'h8888_8888, 5'd8));
    cyc();
    check("commit7_rid", result_id, 4'd7);
    cyc();

    // Repeated commit to id 5: kill then commit, last wins
    commit(1'b1, 4'd5, 1'b1);
    cyc();
    commit(1'b1, 4'd5, 1'b0);
    cyc();
    commit(1'b0, 4'd0, 1'b0);
    drive(1'b1, XFIRDOTP, 4'd5, 5'd12, 32'h5555_AAAA);
    cyc();
    idle_in();
    #1 check("lastwins_wb", wb, wr(32'h5555_AAAA, 5'd12));
    cyc();
    check("lastwins_rvalid", result_valid, 1'b1);
    cyc();

    // Set and clear of id 6 in the same cycle: set survives
    drive(1'b1, XFIRLW, 4'd6, 5'd6, 32'h6666_0001);
    commit(1'b1, 4'd6, 1'b0);
    cyc();
    idle_in();
    #1 check("setclr_wb1", wb.write, 1'b1);
    cyc();
    commit(1'b0, 4'd0, 1'b0);
    drive(1'b1, XFIRLW, 4'd6, 5'd6, 32'h6666_0002);
    cyc();
    idle_in();
    #1 check("setclr_wb2", wb, wr(32'h6666_0002, 5'd6));
    cyc();
    cyc();

    // Reset with a commit pending for the held id 4
    drive(1'b1, XFIRDOTP, 4'd4, 5'd4, 32'h4444_4444);
    cyc();
    idle_in();
    cyc();
    rst = 1'b1;
    commit(1'b1, 4'd4, 1'b0);
    cyc();
    rst = 1'b0;
    commit(1'b0, 4'd0, 1'b0);
    #1 check("rstpend_state", dbg_state, IDLE);
    cyc();
    commit(1'b1, 4'd4, 1'b0);
    cyc();
    commit(1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1 check("rstpend_wb", wb.write, 1'b0);
      check("rstpend_rvalid", result_valid, 1'b0);
      check("rstpend_idle", dbg_state, IDLE);
      cyc();
    end
`else
    // No commit ever sent: fixed one-cycle wait
    drive(1'b1, XFIRDOTP, 4'd9, 5'd17, 32'h0F0F_1234);
    #1 check("nocmt_ready", ex2wb_ready, 1'b1);
    cyc();
    idle_in();
    #1 check("nocmt_wb_n1", wb, wr(32'h0F0F_1234, 5'd17));
    cyc();
    check("nocmt_rvalid_n2", result_valid, 1'b1);
    check("nocmt_rid", result_id, 4'd9);
    check("nocmt_wb_off", wb.write, 1'b0);
    cyc();
    check("nocmt_idle", dbg_state, IDLE);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
